// File: rtl/gpr_pkg.sv
// Shared types and default widths for the GPR writeback arbiter slice.
package gpr_pkg;

    localparam int unsigned GPR_ADDR_W = 5;
    localparam int unsigned GPR_DATA_W = 64;

    typedef enum logic {
        SRC_EXU = 1'b0,
        SRC_LSU = 1'b1
    } wb_src_e;

    typedef struct packed {
        logic                  valid;
        logic [GPR_ADDR_W-1:0] rd;
        logic [GPR_DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/gpr_wb_arbiter_scoreboard.sv
// Load-in-flight scoreboard: busy vector with set/clear and index lookups.
module gpr_scoreboard
    import gpr_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = GPR_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  set_en,
    input  logic [ADDR_WIDTH-1:0] set_idx,
    input  logic                  clr_en,
    input  logic [ADDR_WIDTH-1:0] clr_idx,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    input  logic [ADDR_WIDTH-1:0] rsx,
    output logic                  busy1,
    output logic                  busy2,
    output logic                  busyx
);

    logic [(1<<ADDR_WIDTH)-1:0] r_busy;

    // Set is applied after clear so a same-index collision leaves the bit set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            if (clr_en)
                r_busy[clr_idx] <= 1'b0;
            if (set_en && (set_idx != '0))
                r_busy[set_idx] <= 1'b1;
        end
    end

    always_comb begin
        busy1 = r_busy[rs1] && (rs1 != '0);
        busy2 = r_busy[rs2] && (rs2 != '0);
        busyx = r_busy[rsx] && (rsx != '0);
    end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// GPR write-port arbiter (EXU vs LSU, round-robin) with load scoreboard.
// Optional write-stage forwarding to decode: define GPR_WB_FORWARD_EN.
module gpr_wb_arbiter
    import gpr_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = GPR_ADDR_W,
    parameter int unsigned DATA_WIDTH = GPR_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  exu_valid,
    output logic                  exu_ready,
    input  logic [ADDR_WIDTH-1:0] exu_rd,
    input  logic [DATA_WIDTH-1:0] exu_data,
    input  logic                  lsu_issue,
    input  logic [ADDR_WIDTH-1:0] lsu_issue_rd,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_rd,
    output logic [DATA_WIDTH-1:0] rf_dataD,
    input  logic [ADDR_WIDTH-1:0] id_rs1,
    input  logic [ADDR_WIDTH-1:0] id_rs2,
    input  logic [DATA_WIDTH-1:0] rf_data1,
    input  logic [DATA_WIDTH-1:0] rf_data2,
    output logic [DATA_WIDTH-1:0] id_data1,
    output logic [DATA_WIDTH-1:0] id_data2,
    output logic                  id_stall
);

    logic                  r_wen;
    logic [ADDR_WIDTH-1:0] r_rd;
    logic [DATA_WIDTH-1:0] r_data;
    wb_src_e               r_src;
    wb_src_e               r_last;

    logic w_busy1, w_busy2, w_busy_exu;
    logic w_exu_req, w_grant_exu, w_grant_lsu;
    logic w_fwd_hazard;

    gpr_scoreboard #(.ADDR_WIDTH(ADDR_WIDTH)) u_sb (
        .clk     (clk),
        .rst_n   (rst_n),
        .set_en  (lsu_issue),
        .set_idx (lsu_issue_rd),
        .clr_en  (r_wen && (r_src == SRC_LSU)),
        .clr_idx (r_rd),
        .rs1     (id_rs1),
        .rs2     (id_rs2),
        .rsx     (exu_rd),
        .busy1   (w_busy1),
        .busy2   (w_busy2),
        .busyx   (w_busy_exu)
    );

    // EXU waits behind an outstanding load to the same rd to keep WAW order.
    assign w_exu_req = exu_valid && !w_busy_exu;

    always_comb begin
        w_grant_exu = 1'b0;
        w_grant_lsu = 1'b0;
        if (w_exu_req && lsu_valid) begin
            if (r_last == SRC_EXU)
                w_grant_lsu = 1'b1;
            else
                w_grant_exu = 1'b1;
        end else begin
            w_grant_exu = w_exu_req;
            w_grant_lsu = lsu_valid;
        end
    end

    assign exu_ready = w_grant_exu;
    assign lsu_ready = w_grant_lsu;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wen  <= 1'b0;
            r_rd   <= '0;
            r_data <= '0;
            r_src  <= SRC_EXU;
            r_last <= SRC_EXU;
        end else begin
            r_wen <= 1'b0;
            if (w_grant_lsu) begin
                r_wen  <= (lsu_rd != '0);
                r_rd   <= lsu_rd;
                r_data <= lsu_data;
                r_src  <= SRC_LSU;
                r_last <= SRC_LSU;
            end else if (w_grant_exu) begin
                r_wen  <= (exu_rd != '0);
                r_rd   <= exu_rd;
                r_data <= exu_data;
                r_src  <= SRC_EXU;
                r_last <= SRC_EXU;
            end
        end
    end

    assign rf_wen   = r_wen;
    assign rf_rd    = r_rd;
    assign rf_dataD = r_data;

`ifdef GPR_WB_FORWARD_EN
    always_comb begin
        w_fwd_hazard = 1'b0;
        id_data1 = (r_wen && (r_rd == id_rs1) && (id_rs1 != '0)) ? r_data : rf_data1;
        id_data2 = (r_wen && (r_rd == id_rs2) && (id_rs2 != '0)) ? r_data : rf_data2;
    end
`else
    always_comb begin
        id_data1 = rf_data1;
        id_data2 = rf_data2;
        w_fwd_hazard = r_wen && (((r_rd == id_rs1) && (id_rs1 != '0)) ||
                                 ((r_rd == id_rs2) && (id_rs2 != '0)));
    end
`endif

    assign id_stall = w_busy1 || w_busy2 || w_fwd_hazard;

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Directed self-checking bench for gpr_wb_arbiter (either forwarding build).
module tb_gpr_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        exu_valid, exu_ready;
    logic [4:0]  exu_rd;
    logic [63:0] exu_data;
    logic        lsu_issue;
    logic [4:0]  lsu_issue_rd;
    logic        lsu_valid, lsu_ready;
    logic [4:0]  lsu_rd;
    logic [63:0] lsu_data;
    logic        rf_wen;
    logic [4:0]  rf_rd;
    logic [63:0] rf_dataD;
    logic [4:0]  id_rs1, id_rs2;
    logic [63:0] rf_data1, rf_data2, id_data1, id_data2;
    logic        id_stall;

    int unsigned n_vec  = 0;
    int unsigned n_fail = 0;

    always #5 clk = ~clk;

    gpr_wb_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd), .exu_data(exu_data),
        .lsu_issue(lsu_issue), .lsu_issue_rd(lsu_issue_rd),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_dataD(rf_dataD),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .rf_data1(rf_data1), .rf_data2(rf_data2),
        .id_data1(id_data1), .id_data2(id_data2), .id_stall(id_stall)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        exu_valid = 0; exu_rd = '0; exu_data = '0;
        lsu_issue = 0; lsu_issue_rd = '0;
        lsu_valid = 0; lsu_rd = '0; lsu_data = '0;
        id_rs1 = '0; id_rs2 = '0;
        rf_data1 = 64'h1111; rf_data2 = 64'h2222;
        #12;
        chk("rst_rf_wen", rf_wen, 0);
        chk("rst_rf_rd", rf_rd, 0);
        chk("rst_rf_dataD", rf_dataD, 0);
        chk("rst_exu_ready", exu_ready, 0);
        chk("rst_lsu_ready", lsu_ready, 0);
        chk("rst_stall", id_stall, 0);
        chk("passthru_d1", id_data1, 64'h1111);

        // single EXU write
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); exu_valid = 1; exu_rd = 5'd5; exu_data = 64'h1234;
        #1 chk("exu5_ready", exu_ready, 1);
        chk("exu5_lsu_ready", lsu_ready, 0);
        @(posedge clk); #1;
        chk("exu5_wen", rf_wen, 1);
        chk("exu5_rd", rf_rd, 5);
        chk("exu5_data", rf_dataD, 64'h1234);

        // contention: last=EXU, so LSU, EXU, LSU, EXU
        @(negedge clk);
        exu_valid = 1; exu_rd = 5'd10; exu_data = 64'hE0;
        lsu_valid = 1; lsu_rd = 5'd11; lsu_data = 64'hD0;
        #1 chk("rr0_lsu_ready", lsu_ready, 1);
        chk("rr0_exu_ready", exu_ready, 0);
        @(posedge clk); #1;
        chk("rr0_rd", rf_rd, 11);
        chk("rr0_data", rf_dataD, 64'hD0);
        @(negedge clk); exu_data = 64'hE1; lsu_data = 64'hD1;
        #1 chk("rr1_exu_ready", exu_ready, 1);
        chk("rr1_lsu_ready", lsu_ready, 0);
        @(posedge clk); #1;
        chk("rr1_rd", rf_rd, 10);
        chk("rr1_data", rf_dataD, 64'hE1);
        @(negedge clk); exu_data = 64'hE2; lsu_data = 64'hD2;
        #1 chk("rr2_lsu_ready", lsu_ready, 1);
        @(posedge clk); #1;
        chk("rr2_data", rf_dataD, 64'hD2);
        @(negedge clk); exu_data = 64'hE3; lsu_data = 64'hD3;
        #1 chk("rr3_exu_ready", exu_ready, 1);
        @(posedge clk); #1;
        chk("rr3_data", rf_dataD, 64'hE3);
        chk("rr3_wen", rf_wen, 1);

        // load to r7 in flight: stall and hold EXU r7
        @(negedge clk);
        exu_valid = 0; lsu_valid = 0;
        lsu_issue = 1; lsu_issue_rd = 5'd7;
        @(negedge clk);
        lsu_issue = 0; id_rs1 = 5'd7;
        exu_valid = 1; exu_rd = 5'd7; exu_data = 64'h77;
        #1 chk("ld7_stall_a", id_stall, 1);
        chk("ld7_exu_hold_a", exu_ready, 0);
        @(negedge clk);
        #1 chk("ld7_stall_b", id_stall, 1);
        chk("ld7_exu_hold_b", exu_ready, 0);
        chk("ld7_idle_wen", rf_wen, 0);
        @(negedge clk); lsu_valid = 1; lsu_rd = 5'd7; lsu_data = 64'hBEEF;
        #1 chk("ld7_lsu_ready", lsu_ready, 1);
        chk("ld7_exu_hold_c", exu_ready, 0);
        @(posedge clk); #1;
        chk("ld7_wen", rf_wen, 1);
        chk("ld7_rd", rf_rd, 7);
        chk("ld7_data", rf_dataD, 64'hBEEF);
        @(negedge clk); lsu_valid = 0;
        #1 chk("ld7_stall_wb", id_stall, 1);
        chk("ld7_exu_hold_d", exu_ready, 0);
        @(negedge clk);
        #1 chk("ld7_stall_clear", id_stall, 0);
        chk("ld7_exu_go", exu_ready, 1);
        @(posedge clk); #1;
        chk("exu7_wen", rf_wen, 1);
        chk("exu7_data", rf_dataD, 64'h77);

        // x0 write
        @(negedge clk); id_rs1 = '0; exu_rd = '0; exu_data = 64'hFFFF;
        #1 chk("x0_ready", exu_ready, 1);
        @(posedge clk); #1;
        chk("x0_wen", rf_wen, 0);

        // write r3 then read it in the write-stage cycle
        @(negedge clk); exu_rd = 5'd3; exu_data = 64'hAA;
        @(negedge clk); exu_valid = 0; id_rs2 = 5'd3; rf_data2 = 64'h55;
        #1 chk("fw_wen", rf_wen, 1);
`ifdef GPR_WB_FORWARD_EN
        chk("fw_data2", id_data2, 64'hAA);
        chk("fw_stall", id_stall, 0);
`else
        chk("nofw_data2", id_data2, 64'h55);
        chk("nofw_stall", id_stall, 1);
`endif
        @(negedge clk);
        #1 chk("fw_after_stall", id_stall, 0);
        chk("fw_after_data2", id_data2, 64'h55);

        // async reset with busy[9] set and a write in the stage
        @(negedge clk); id_rs2 = '0;
        lsu_issue = 1; lsu_issue_rd = 5'd9;
        exu_valid = 1; exu_rd = 5'd4; exu_data = 64'h44;
        @(negedge clk); lsu_issue = 0; exu_valid = 0; id_rs1 = 5'd9;
        #1 chk("pre_rst_stall", id_stall, 1);
        chk("pre_rst_wen", rf_wen, 1);
        #1 rst_n = 1'b0;
        #1 chk("async_rst_wen", rf_wen, 0);
        chk("async_rst_rd", rf_rd, 0);
        chk("async_rst_data", rf_dataD, 0);
        chk("async_rst_busy", id_stall, 0);

        // after reset LSU wins the first tie
        @(negedge clk); rst_n = 1'b1; id_rs1 = '0;
        @(negedge clk);
        exu_valid = 1; exu_rd = 5'd1; exu_data = 64'h1;
        lsu_valid = 1; lsu_rd = 5'd2; lsu_data = 64'h2;
        #1 chk("post_rst_lsu_first", lsu_ready, 1);
        chk("post_rst_exu_wait", exu_ready, 0);
        @(negedge clk); exu_valid = 0; lsu_valid = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
